inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end that feeds the core's `ir` input. It owns the fetch PC, issues word-addressed reads to instruction memory over a hold-until-valid handshake, and buffers fetched words with their PCs in a small queue. The core consumes instructions through a valid/ready pair. Branches and jumps flush the queue through a redirect port.

## Interface
Parameters:
- `DEPTH`, 4: instruction queue entries, power of two, ≥2.
- `RESET_PC`, 32'd0: fetch PC after reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `redirect` in 1: core requests a new fetch stream (taken branch or jump).
- `redirect_pc` in 32: target word address; sampled when `redirect`=1.
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out 32: word address of the request.
- `mem_rvalid` in 1: `mem_rdata` is valid for the current `mem_addr`. Legal only while `mem_req`=1, including the first cycle of the request.
- `mem_rdata` in 32: instruction word.
- `ir_valid` out 1: queue head is valid.
- `ir` out 32: head instruction; 32'h0 when empty.
- `ir_pc` out 32: word address of the head instruction; 32'h0 when empty.
- `ir_ready` in 1: core consumes the head this cycle.

## Operation
- State machine with three states: IDLE, REQ, DROP. `mem_req` = (state != IDLE); `mem_addr` is registered.
- Occupancy `count` ranges from 0 to DEPTH. The fetch PC `fpc` is a 32-bit counter that wraps 32'hFFFF_FFFF→0.
- IDLE → REQ when `count_next` < DEPTH and `redirect`=0. At that transition `mem_addr` ← `fpc`.
- REQ, `mem_rvalid`=1, `redirect`=0:
  - Push {`fpc`, `mem_rdata`} and set `fpc` ← `fpc`+1.
  - If there is still space (`count_next` < DEPTH), stay in REQ with `mem_addr` ← `fpc`+1; this gives back-to-back fetches.
  - Otherwise go to IDLE.
- REQ, `mem_rvalid`=0: hold `mem_req` and `mem_addr` stable. A request is never withdrawn before `mem_rvalid`.
- `redirect`=1 in any state:
  - The queue is flushed (`count` ← 0) and `fpc` ← `redirect_pc`. A simultaneous `ir_ready` pop is ignored.
  - If state is REQ and `mem_rvalid`=0, go to DROP.
  - Otherwise go to IDLE; a coincident `mem_rvalid` word is discarded.
- DROP: keep the stale `mem_addr`/`mem_req` until `mem_rvalid`, discard that data, then go to IDLE.
  - `redirect` again while in DROP: update `fpc` and stay in DROP.
- Pop: the head is removed when `ir_valid` && `ir_ready` && !`redirect`.
- Push and pop in the same cycle are allowed; `count` is unchanged.
  - `count_next` = `count` + push − pop, where pop is evaluated before the space check. A full queue with a pop may therefore stay in REQ.
- `ir_ready` while empty has no effect. Push is never performed when `count`=DEPTH.

## Timing
- Reset values: state=IDLE, `count`=0, `fpc`=RESET_PC, `mem_req`=0, `mem_addr`=0, `ir_valid`=0, `ir`=0, `ir_pc`=0.
- `rst` overrides `redirect` and any in-flight request; any later `mem_rvalid` is ignored because `mem_req`=0.
- First `rst`=0 edge E0: IDLE→REQ, so `mem_req`=1 after E0. With a zero-wait memory (`mem_rvalid`=1 immediately), the push happens at E1 and `ir_valid`=1 after E1.
- Throughput: 1 instruction/cycle with a zero-wait memory and `ir_ready` held high.
- Redirect at edge E:
  - `ir_valid`=0 after E.
  - Without DROP, the new `mem_addr`=`redirect_pc` is presented after E+1.
  - With DROP, it is presented one edge after the stale `mem_rvalid`.
- All outputs are registered or driven directly from the queue head; there is no combinational path from `mem_rvalid` or `ir_ready` to any output.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t` {IDLE, REQ, DROP};
  - `NOP_INSTR` = 32'h0;
  - the entry struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`: synchronous FIFO of DEPTH entries with flush, push, pop, count, and head outputs. Pointers wrap modulo DEPTH.
- Top level: FSM, `fpc`, memory-side registers.

## Test plan
- Reset, zero-wait ROM with mem[i]=32'h1000+i, `ir_ready`=1 → `ir`=32'h1000, 32'h1001, … with `ir_pc`=0, 1, … on consecutive cycles starting 2 edges after reset release.
- `ir_ready`=0, zero-wait ROM → exactly 4 pushes, then `mem_req`=0, `count`=4. Raising `ir_ready` for 1 cycle → pop one, 1 new request issued, head becomes mem[1].
- 3-cycle-latency memory, redirect to 32'h40 on the request's first cycle → `mem_addr` holds its old value until `mem_rvalid`, data discarded, next `mem_addr`=32'h40, first `ir_pc`=32'h40.
- Redirect coincident with `mem_rvalid` and `ir_ready` while `count`=2 → queue empty next cycle, no push, no pop of stale data, next request at `redirect_pc`.
- `redirect_pc`=32'hFFFF_FFFF, zero-wait ROM → `ir_pc` sequence 32'hFFFF_FFFF, 32'h0, 32'h1.
- `rst` asserted during DROP with `mem_rvalid` arriving the next cycle → all outputs at reset values, no push, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   fetch_state_t : fetch FSM states (IDLE, REQ, DROP)
//   NOP_INSTR     : value presented on the instruction output when the queue is empty
//   fetch_entry_t : one queue entry, the word address and the fetched word
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: synchronous FIFO of DEPTH fetch entries.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empties the queue; a coincident push or pop is dropped
//   push, entry : write one entry at the tail (ignored when full)
//   pop         : remove the head entry (ignored when empty)
//   count       : occupancy 0..DEPTH
//   head_valid  : queue not empty
//   head        : head entry, all-zero (NOP at pc 0) when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic [AW:0]    count_next_s;
  logic           do_push_s;
  logic           do_pop_s;

  // Qualify requests against occupancy so the queue can never over/underflow.
  always_comb begin
    do_push_s = push && !flush && (count_r != FULL_COUNT);
    do_pop_s  = pop  && !flush && (count_r != '0);
  end

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + (AW+1)'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - (AW+1)'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer and occupancy registers; power-of-two DEPTH makes the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are only observed through head when non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= entry;
    end
  end

  // Head view: forced to NOP at address 0 while empty.
  always_comb begin
    head_valid = (count_r != '0);
    if (head_valid) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = '{pc: 32'h0000_0000, instr: NOP_INSTR};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word reads to
// instruction memory with a hold-until-valid handshake, and queues the
// fetched words (with their addresses) for the core.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   redirect, redirect_pc  : flush the queue and restart fetching at redirect_pc
//   mem_req, mem_addr      : read request and registered word address
//   mem_rvalid, mem_rdata  : read response for the current mem_addr
//   ir_valid, ir, ir_pc    : queue head towards the core (zeros when empty)
//   ir_ready               : core consumes the head this cycle
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t  state_r;
  fetch_state_t  state_next_s;
  logic [31:0]   fpc_r;
  logic [31:0]   fpc_next_s;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_addr_next_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_next_s;
  logic          head_valid_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;

  // A redirect wins over both the returning word and the core's pop.
  always_comb begin
    pop_s        = head_valid_s && ir_ready && !redirect;
    push_s       = (state_r == REQ) && mem_rvalid && !redirect;
    push_entry_s = '{pc: fpc_r, instr: mem_rdata};
  end

  // Occupancy after this cycle; the pop is counted before deciding whether there is room.
  always_comb begin
    count_next_s = count_s;
    if (push_s && !pop_s) begin
      count_next_s = count_s + CW'(1);
    end else if (!push_s && pop_s) begin
      count_next_s = count_s - CW'(1);
    end else begin
      count_next_s = count_s;
    end
  end

  // Fetch FSM, fetch PC and request address next-state logic.
  always_comb begin
    state_next_s    = state_r;
    fpc_next_s      = fpc_r;
    mem_addr_next_s = mem_addr_r;
    if (redirect) begin
      fpc_next_s = redirect_pc;
      // An outstanding request cannot be withdrawn: wait out its response in DROP.
      if ((state_r != IDLE) && !mem_rvalid) begin
        state_next_s = DROP;
      end else begin
        state_next_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (count_next_s < FULL_COUNT) begin
            state_next_s    = REQ;
            mem_addr_next_s = fpc_r;
          end else begin
            state_next_s = IDLE;
          end
        end
        REQ: begin
          if (mem_rvalid) begin
            fpc_next_s = fpc_r + 32'd1;
            if (count_next_s < FULL_COUNT) begin
              state_next_s    = REQ;
              mem_addr_next_s = fpc_r + 32'd1;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            state_next_s = REQ;
          end
        end
        DROP: begin
          if (mem_rvalid) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DROP;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      fpc_r      <= RESET_PC;
      mem_addr_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      fpc_r      <= fpc_next_s;
      mem_addr_r <= mem_addr_next_s;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push_s),
    .entry      (push_entry_s),
    .pop        (pop_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign mem_req  = (state_r != IDLE);
  assign mem_addr = mem_addr_r;
  assign ir_valid = head_valid_s;
  assign ir       = head_s.instr;
  assign ir_pc    = head_s.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. The memory model answers every
// request after a programmable latency with rom(addr) = 32'h1000 + addr.
// A stream scoreboard expects consumed instructions at consecutive word
// addresses starting from the reset PC or the last redirect target.
module tb_inst_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  bit          rand_lat = 1'b0;
  bit          force_rvalid = 1'b0;
  bit          last_hs = 1'b0;
  int          hs_count = 0;
  int          consumed = 0;
  logic [31:0] exp_pc = RESET_PC;

  inst_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h0000_1000 + a;
  endfunction

  // One clock: memory answers at the falling edge, scoreboard checks the
  // pre-edge view, then post-edge protocol checks at rising edge + 1.
  task automatic cycle();
    logic p_req, p_rv, p_valid, p_ready, p_redir, p_rst;
    logic [31:0] p_addr, p_ir, p_irpc, p_rpc;
    @(negedge clk);
    mem_rvalid = force_rvalid || (mem_req === 1'b1 && wait_cnt >= lat);
    mem_rdata  = force_rvalid ? 32'hBAD0_0000 : (mem_rvalid ? rom(mem_addr) : 32'hDEAD_BEEF);
    p_req = mem_req; p_rv = mem_rvalid; p_valid = ir_valid; p_ready = ir_ready;
    p_redir = redirect; p_rst = rst; p_addr = mem_addr; p_ir = ir; p_irpc = ir_pc;
    p_rpc = redirect_pc;
    if (!p_rst && p_valid === 1'b0) begin
      checks++;
      if (p_ir !== 32'h0 || p_irpc !== 32'h0) begin
        errors++;
        $display("FAIL empty_head: ir=%h ir_pc=%h required 0/0", p_ir, p_irpc);
      end
    end
    if (!p_rst && !p_redir && p_valid === 1'b1 && p_ready) begin
      checks++;
      if (p_irpc !== exp_pc || p_ir !== rom(exp_pc)) begin
        errors++;
        $display("FAIL stream: ir_pc=%h ir=%h required ir_pc=%h ir=%h",
                 p_irpc, p_ir, exp_pc, rom(exp_pc));
      end
      exp_pc = exp_pc + 32'd1;
      consumed++;
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    last_hs = (p_req === 1'b1) && p_rv && !p_rst;
    if (last_hs) hs_count++;
    if (p_rst) begin
      exp_pc   = RESET_PC;
      wait_cnt = 0;
    end else begin
      if (p_redir) begin
        exp_pc = p_rpc;
        checks++;
        if (ir_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_flush: ir_valid=%b required 0", ir_valid);
        end
      end
      if (p_req === 1'b1 && !p_rv) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== p_addr) begin
          errors++;
          $display("FAIL req_hold: mem_req=%b mem_addr=%h required 1/%h", mem_req, mem_addr, p_addr);
        end
        wait_cnt++;
      end else if (p_req === 1'b1 && p_rv) begin
        wait_cnt = 0;
        if (rand_lat) lat = int'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat = 0; ir_ready = 1'b1;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234;
    repeat (3) cycle();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h valid=%b ir=%h pc=%h required all 0",
               mem_req, mem_addr, ir_valid, ir, ir_pc);
    end
  endtask

  task automatic test_stream();
    lat = 0; ir_ready = 1'b1;
    do_reset();
    cycle();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b required 1/%h/0", mem_req, mem_addr, ir_valid, RESET_PC);
    end
    cycle();
    checks++;
    if (ir_valid !== 1'b1 || ir !== 32'h1000 || ir_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_instr: valid=%b ir=%h pc=%h required 1/00001000/0", ir_valid, ir, ir_pc);
    end
    for (int k = 1; k < 8; k++) begin
      cycle();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'(k) || ir !== 32'h1000 + 32'(k)) begin
        errors++;
        $display("FAIL throughput: valid=%b pc=%h ir=%h required 1/%h/%h",
                 ir_valid, ir_pc, ir, 32'(k), 32'h1000 + 32'(k));
      end
    end
  endtask

  task automatic test_full();
    lat = 0; ir_ready = 1'b0;
    do_reset();
    hs_count = 0;
    repeat (10) cycle();
    checks++;
    if (hs_count !== 4 || mem_req !== 1'b0 || ir_pc !== 32'h0 || ir !== 32'h1000) begin
      errors++;
      $display("FAIL fill: fetches=%0d req=%b pc=%h ir=%h required 4/0/0/00001000", hs_count, mem_req, ir_pc, ir);
    end
    ir_ready = 1'b1;
    cycle();
    ir_ready = 1'b0;
    checks++;
    if (ir_pc !== 32'h1 || ir !== 32'h1001 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL pop_refill: pc=%h ir=%h req=%b addr=%h required 1/00001001/1/4", ir_pc, ir, mem_req, mem_addr);
    end
    cycle();
    checks++;
    if (hs_count !== 5 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL refill_once: fetches=%0d req=%b required 5/0", hs_count, mem_req);
    end
  endtask

  task automatic test_drop();
    lat = 3; ir_ready = 1'b1;
    do_reset();
    cycle();
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold: req=%b addr=%h valid=%b required 1/0/0", mem_req, mem_addr, ir_valid);
    end
    for (int i = 0; i < 10 && !last_hs; i++) cycle();
    checks++;
    if (last_hs !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: response_seen=%b req=%b valid=%b required 1/0/0", last_hs, mem_req, ir_valid);
    end
    cycle();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL drop_restart: req=%b addr=%h required 1/00000040", mem_req, mem_addr);
    end
    for (int i = 0; i < 10 && ir_valid !== 1'b1; i++) cycle();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h40 || ir !== rom(32'h40)) begin
      errors++;
      $display("FAIL drop_first: valid=%b pc=%h ir=%h required 1/00000040/%h", ir_valid, ir_pc, ir, rom(32'h40));
    end
  endtask

  task automatic test_redirect_coincident();
    lat = 0; ir_ready = 1'b0;
    do_reset();
    repeat (3) cycle();
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL coincident_flush: valid=%b ir=%h pc=%h req=%b required 0/0/0/0", ir_valid, ir, ir_pc, mem_req);
    end
    cycle();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL coincident_req: req=%b addr=%h valid=%b required 1/00000080/0", mem_req, mem_addr, ir_valid);
    end
    cycle();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h80 || ir !== rom(32'h80)) begin
      errors++;
      $display("FAIL coincident_first: valid=%b pc=%h ir=%h required 1/00000080/%h", ir_valid, ir_pc, ir, rom(32'h80));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFF; want[1] = 32'h0; want[2] = 32'h1;
    lat = 0; ir_ready = 1'b1;
    do_reset();
    cycle();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cycle();
    redirect = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== want[i] || ir !== rom(want[i])) begin
        errors++;
        $display("FAIL wrap: valid=%b pc=%h ir=%h required 1/%h/%h", ir_valid, ir_pc, ir, want[i], rom(want[i]));
      end
    end
  endtask

  task automatic test_rst_in_drop();
    lat = 3; ir_ready = 1'b1;
    do_reset();
    cycle();
    redirect = 1'b1; redirect_pc = 32'h55;
    cycle();
    redirect = 1'b0;
    rst = 1'b1;
    cycle();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_drop: req=%b addr=%h valid=%b ir=%h pc=%h required all 0",
               mem_req, mem_addr, ir_valid, ir, ir_pc);
    end
    rst = 1'b0; force_rvalid = 1'b1;
    cycle();
    force_rvalid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart: req=%b addr=%h valid=%b required 1/%h/0", mem_req, mem_addr, ir_valid, RESET_PC);
    end
    lat = 0;
    cycle();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== RESET_PC || ir !== rom(RESET_PC)) begin
      errors++;
      $display("FAIL rst_first: valid=%b pc=%h ir=%h required 1/%h/%h", ir_valid, ir_pc, ir, RESET_PC, rom(RESET_PC));
    end
  endtask

  task automatic test_random();
    rand_lat = 1'b1; lat = 1; ir_ready = 1'b1;
    do_reset();
    consumed = 0;
    for (int i = 0; i < 800; i++) begin
      ir_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end
    redirect = 1'b0;
    rand_lat = 1'b0;
    checks++;
    if (consumed < 80) begin
      errors++;
      $display("FAIL random_progress: consumed=%0d required at least 80", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_coincident();
    test_wrap();
    test_rst_in_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
